// File: rtl/raster_scan_driver.sv
// Raster scan timing generator: issues x/y to a pixel pipeline and re-aligns
// the returned colour with delayed sync, data-enable and frame/line markers.
module raster_scan_driver #(
  parameter int H_ACTIVE        = 1024,
  parameter int H_FRONT         = 24,
  parameter int H_SYNC          = 136,
  parameter int H_BACK          = 160,
  parameter int V_ACTIVE        = 768,
  parameter int V_FRONT         = 3,
  parameter int V_SYNC          = 6,
  parameter int V_BACK          = 29,
  parameter int PIPE_LATENCY    = 2,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  r_in,
  input  logic [7:0]  g_in,
  input  logic [7:0]  b_in,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_start,
  output logic        line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  // Delay-line entry layout: {active, hsync, vsync, frame, line}, all active-high.
  localparam int E_ACT   = 4;
  localparam int E_HS    = 3;
  localparam int E_VS    = 2;
  localparam int E_FRAME = 1;
  localparam int E_LINE  = 0;

  logic [10:0] h;
  logic [9:0]  v;
  logic [11:0] h_ext;
  logic [10:0] v_ext;
  logic        h_last;
  logic        v_last;
  logic [4:0]  raw;
  logic [4:0]  tail;

  assign h_ext  = {1'b0, h};
  assign v_ext  = {1'b0, v};
  assign h_last = (h_ext == H_LAST);
  assign v_last = (v_ext == V_LAST);

  assign x = h;
  assign y = v;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h <= '0;
      v <= '0;
    end else if (!en) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + 10'd1;
    end else begin
      h <= h + 11'd1;
    end
  end

  // A disabled scan feeds blank entries so the outputs drain cleanly.
  always_comb begin
    raw = '0;
    if (en) begin
      raw[E_ACT]   = (h_ext < H_ACT) && (v_ext < V_ACT);
      raw[E_HS]    = (h_ext >= HS_START) && (h_ext < HS_END);
      raw[E_VS]    = (v_ext >= VS_START) && (v_ext < VS_END);
      raw[E_FRAME] = (h == 11'd0) && (v == 10'd0);
      raw[E_LINE]  = (h == 11'd0) && (v_ext < V_ACT);
    end
  end

  generate
    if (PIPE_LATENCY == 0) begin : g_no_pipe
      assign tail = raw;
    end else begin : g_pipe
      logic [4:0] stage [PIPE_LATENCY];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < PIPE_LATENCY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= raw;
          for (int i = 1; i < PIPE_LATENCY; i++) stage[i] <= stage[i-1];
        end
      end

      assign tail = stage[PIPE_LATENCY-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      hsync       <= SYNC_IDLE;
      vsync       <= SYNC_IDLE;
      r_out       <= 8'd0;
      g_out       <= 8'd0;
      b_out       <= 8'd0;
    end else begin
      de          <= tail[E_ACT];
      frame_start <= tail[E_FRAME];
      line_start  <= tail[E_LINE];
      hsync       <= tail[E_HS] ^ SYNC_IDLE;
      vsync       <= tail[E_VS] ^ SYNC_IDLE;
      r_out       <= tail[E_ACT] ? r_in : 8'd0;
      g_out       <= tail[E_ACT] ? g_in : 8'd0;
      b_out       <= tail[E_ACT] ? b_in : 8'd0;
    end
  end

endmodule
